// File: rtl/demux_regbank4_pkg.sv
// Shared sizing and index type for the four-entry write-side register bank.
package regbank_pkg;
  localparam int NUM_ENTRIES = 4;
  localparam int ADDR_W      = 2;
  typedef logic [ADDR_W-1:0] entry_idx_t;
endpackage

// File: rtl/decoder2x4.sv
// Combinational 2-to-4 one-hot decoder; the write-side inverse of a 4:1 mux.
module decoder2x4
  import regbank_pkg::*;
(
  input  entry_idx_t                   addr,
  input  logic                         en,
  output logic [NUM_ENTRIES-1:0]       out
);
  always_comb begin
    out = '0;
    if (en) out[addr] = 1'b1;
  end
endmodule

// File: rtl/demux_regbank4.sv
// Four-entry register bank fed through a registered commit stage, exposing the
// in-flight write so readers can forward around it.
module demux_regbank4
  import regbank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  entry_idx_t                          wr_addr,
  input  logic [WIDTH-1:0]                    wr_data,
  input  logic                                inv_en,
  input  entry_idx_t                          inv_addr,
  input  logic                                flush,
  output logic [NUM_ENTRIES-1:0][WIDTH-1:0]   q,
  output logic [NUM_ENTRIES-1:0]              valid,
  output logic                                pend_valid,
  output entry_idx_t                          pend_addr,
  output logic [WIDTH-1:0]                    pend_data,
  output logic [NUM_ENTRIES-1:0]              wr_onehot
);
  logic                               pend_valid_q, pend_valid_d;
  entry_idx_t                         pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0]                   pend_data_q, pend_data_d;
  logic [NUM_ENTRIES-1:0][WIDTH-1:0]  q_q;
  logic [NUM_ENTRIES-1:0]             valid_q;

  // A write arriving alongside flush is dropped, so it never reaches the commit stage.
  always_comb begin
    pend_valid_d = wr_en & ~flush;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (wr_en && !flush) begin
      pend_addr_d = wr_addr;
      pend_data_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  decoder2x4 u_dec (
    .addr (pend_addr_q),
    .en   (pend_valid_q),
    .out  (wr_onehot)
  );

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    logic commit;
    assign commit = wr_onehot[i] & ~flush;

    always_ff @(posedge clk) begin
      if (reset) begin
        q_q[i]     <= '0;
        valid_q[i] <= 1'b0;
      end else begin
        if (commit) q_q[i] <= pend_data_q;
        // Commit outranks a same-cycle invalidate of the same entry.
        if (flush)                                    valid_q[i] <= 1'b0;
        else if (commit)                              valid_q[i] <= 1'b1;
        else if (inv_en && inv_addr == entry_idx_t'(i)) valid_q[i] <= 1'b0;
      end
    end
  end

  assign q          = q_q;
  assign valid      = valid_q;
  assign pend_valid = pend_valid_q;
  assign pend_addr  = pend_addr_q;
  assign pend_data  = pend_data_q;
endmodule

// File: tb/tb_demux_regbank4.sv
// Directed-vector bench for demux_regbank4: a 32-bit instance for the scenarios
// and a 4-bit instance sharing controls for the exhaustive address/data sweep.
module tb_demux_regbank4;
  logic        clk = 1'b0;
  logic        reset, wr_en, inv_en, flush;
  logic [1:0]  wr_addr, inv_addr;
  logic [31:0] wr_data;

  logic [3:0][31:0] q;
  logic [3:0]       valid, wr_onehot;
  logic             pend_valid;
  logic [1:0]       pend_addr;
  logic [31:0]      pend_data;

  logic [3:0][3:0]  q4;
  logic [3:0]       valid4, wr_onehot4;
  logic             pend_valid4;
  logic [1:0]       pend_addr4;
  logic [3:0]       pend_data4;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_regbank4 #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
    .q(q), .valid(valid), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .pend_data(pend_data), .wr_onehot(wr_onehot)
  );

  demux_regbank4 #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[3:0]),
    .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
    .q(q4), .valid(valid4), .pend_valid(pend_valid4), .pend_addr(pend_addr4),
    .pend_data(pend_data4), .wr_onehot(wr_onehot4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; inv_en = 0; flush = 0; reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; wr_en = 0; inv_en = 0; flush = 0;
    wr_addr = 0; inv_addr = 0; wr_data = 0;
    step(); step();
    nvec++; if (q !== '0) begin nerr++; $display("FAIL reset_q got=%h exp=0", q); end
    nvec++; if (valid !== 4'b0000) begin nerr++; $display("FAIL reset_valid got=%b exp=0000", valid); end
    nvec++; if (pend_valid !== 1'b0 || pend_addr !== 2'd0 || pend_data !== 32'd0) begin
      nerr++; $display("FAIL reset_pend got=%b/%0d/%h exp=0/0/0", pend_valid, pend_addr, pend_data); end
    nvec++; if (wr_onehot !== 4'b0000) begin nerr++; $display("FAIL reset_onehot got=%b exp=0000", wr_onehot); end
    reset = 0;
  endtask

  task automatic test_fill();
    logic [3:0] exp_oh;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = 2'(i); wr_data = 32'hA5A5_0001 + 32'(i);
      step();
      exp_oh = 4'b0001 << i;
      nvec++; if (wr_onehot !== exp_oh || pend_data !== 32'hA5A5_0001 + 32'(i)) begin
        nerr++; $display("FAIL fill_pend[%0d] got=%b/%h exp=%b/%h", i, wr_onehot, pend_data, exp_oh, 32'hA5A5_0001 + 32'(i)); end
    end
    idle(); step();
    nvec++; if (q !== {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001}) begin
      nerr++; $display("FAIL fill_q got=%h", q); end
    nvec++; if (valid !== 4'b1111 || wr_onehot !== 4'b0000) begin
      nerr++; $display("FAIL fill_valid got=%b/%b exp=1111/0000", valid, wr_onehot); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1; wr_addr = 2; wr_data = 32'h11; step();
    nvec++; if (pend_data !== 32'h11) begin nerr++; $display("FAIL b2b_first got=%h exp=11", pend_data); end
    wr_data = 32'h22; step();
    nvec++; if (pend_data !== 32'h22 || q[2] !== 32'h11) begin
      nerr++; $display("FAIL b2b_second got=%h/%h exp=22/11", pend_data, q[2]); end
    idle(); step();
    nvec++; if (q !== {32'hA5A5_0004, 32'h22, 32'hA5A5_0002, 32'hA5A5_0001}) begin
      nerr++; $display("FAIL b2b_q got=%h", q); end
  endtask

  task automatic test_conflict();
    wr_en = 1; wr_addr = 1; wr_data = 32'h33; step();
    wr_en = 0; inv_en = 1; inv_addr = 1; step();
    nvec++; if (valid !== 4'b1111 || q[1] !== 32'h33) begin
      nerr++; $display("FAIL conflict_same got=%b/%h exp=1111/33", valid, q[1]); end
    step();
    nvec++; if (valid !== 4'b1101 || q[1] !== 32'h33) begin
      nerr++; $display("FAIL inv_alone got=%b/%h exp=1101/33", valid, q[1]); end
    // Commit to entry 2 while invalidating entry 0: both apply.
    inv_en = 0; wr_en = 1; wr_addr = 2; wr_data = 32'h77; step();
    wr_en = 0; inv_en = 1; inv_addr = 0; step();
    nvec++; if (valid !== 4'b1100 || q[2] !== 32'h77 || q[0] !== 32'hA5A5_0001) begin
      nerr++; $display("FAIL conflict_diff got=%b/%h/%h exp=1100/77/a5a50001", valid, q[2], q[0]); end
    idle();
  endtask

  task automatic test_flush();
    wr_en = 1; wr_addr = 0; wr_data = 32'h44; step();
    wr_en = 0; flush = 1; step();
    nvec++; if (pend_valid !== 1'b0 || valid !== 4'b0000 || q[0] !== 32'hA5A5_0001) begin
      nerr++; $display("FAIL flush_inflight got=%b/%b/%h exp=0/0000/a5a50001", pend_valid, valid, q[0]); end
    wr_en = 1; wr_addr = 3; wr_data = 32'h99; flush = 1; step();
    nvec++; if (pend_valid !== 1'b0 || wr_onehot !== 4'b0000) begin
      nerr++; $display("FAIL flush_same_wr got=%b/%b exp=0/0000", pend_valid, wr_onehot); end
    idle(); step();
    nvec++; if (q[3] !== 32'hA5A5_0004 || valid !== 4'b0000) begin
      nerr++; $display("FAIL flush_after got=%h/%b exp=a5a50004/0000", q[3], valid); end
  endtask

  task automatic test_reset_mid();
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; step();
    wr_en = 0; reset = 1; step();
    nvec++; if (q !== '0 || valid !== 4'b0000 || pend_valid !== 1'b0 || wr_onehot !== 4'b0000) begin
      nerr++; $display("FAIL reset_mid got=%h/%b/%b/%b", q, valid, pend_valid, wr_onehot); end
    idle();
  endtask

  task automatic test_exhaustive();
    logic [3:0][3:0] sb_q;
    logic [3:0]      sb_v;
    logic            p_v;
    logic [1:0]      p_a;
    logic [3:0]      p_d;
    reset = 1; step(); idle();
    sb_q = '0; sb_v = '0; p_v = 0; p_a = 0; p_d = 0;
    for (int k = 0; k < 65; k++) begin
      if (p_v) begin sb_q[p_a] = p_d; sb_v[p_a] = 1'b1; end
      wr_en = (k < 64); wr_addr = 2'(k); wr_data = 32'(k >> 2);
      p_v = (k < 64); p_a = 2'(k); p_d = 4'(k >> 2);
      step();
      nvec++; if (q4 !== sb_q || valid4 !== sb_v || pend_valid4 !== p_v ||
                  (p_v && (pend_addr4 !== p_a || pend_data4 !== p_d))) begin
        nerr++; $display("FAIL sweep[%0d] got q=%h v=%b pv=%b pa=%0d pd=%h exp q=%h v=%b pv=%b pa=%0d pd=%h",
                         k, q4, valid4, pend_valid4, pend_addr4, pend_data4, sb_q, sb_v, p_v, p_a, p_d); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_conflict();
    test_flush();
    test_reset_mid();
    test_exhaustive();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
